// File: rtl/x_wb_sched_pkg.sv
// Shared constants for the write-back scheduler: index width, data width,
// requester count and requester ids.
package x_wb_sched_pkg;

  localparam int REG_IDX_W = 5;
  localparam int N_REGS    = 1 << REG_IDX_W;
  localparam int XLEN_DEF  = 32;
  localparam int N_REQ_DEF = 3;

  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;
  localparam int REQ_VEC = 2;

  // Width of a pointer that selects one of n requesters (at least 1 bit).
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/x_wb_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request found
// scanning upward from ptr, wrapping at N.
module rr_arbiter
  import x_wb_sched_pkg::*;
#(
  parameter int N = N_REQ_DEF
) (
  input  logic [N-1:0]          req,
  input  logic [ptr_w(N)-1:0]   ptr,
  output logic [N-1:0]          gnt
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    logic found;
    int   idx;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/x_wb_sched.sv
// Write-back scheduler: round-robin arbitration of result writers into a
// single register-file write port, plus the issue-side pending scoreboard.
module x_wb_sched
  import x_wb_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int XLEN  = XLEN_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [REG_IDX_W*N_REQ-1:0]  req_rd,
  input  logic [XLEN*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]            req_ready,
  input  logic                        iss_valid,
  input  logic [REG_IDX_W-1:0]        iss_rd,
  input  logic [REG_IDX_W-1:0]        iss_rs1,
  input  logic [REG_IDX_W-1:0]        iss_rs2,
  output logic                        iss_ready,
  output logic                        reg_w,
  output logic [REG_IDX_W-1:0]        rd,
  output logic [XLEN-1:0]             w_data,
  output logic                        wb_err
);

  localparam int PW = ptr_w(N_REQ);

  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic                  reg_w_q, reg_w_d;
  logic [REG_IDX_W-1:0]  rd_q, rd_d;
  logic [XLEN-1:0]       w_data_q, w_data_d;
  logic [N_REGS-1:0]     pending_q, pending_d;
  logic                  wb_err_q, wb_err_d;

  logic [N_REQ-1:0]      gnt;
  logic                  grant_any;
  logic [PW-1:0]         g_idx;
  logic [REG_IDX_W-1:0]  g_rd;
  logic [XLEN-1:0]       g_data;
  logic                  hazard;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (gnt)
  );

  assign req_ready = gnt;

  always_comb begin
    grant_any = 1'b0;
    g_idx     = '0;
    g_rd      = '0;
    g_data    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        grant_any = 1'b1;
        g_idx     = PW'(i);
        g_rd      = req_rd[REG_IDX_W*i +: REG_IDX_W];
        g_data    = req_data[XLEN*i +: XLEN];
      end
    end
  end

  // pending_q[0] is held at 0, so x0 operands never stall the issue stage.
  assign hazard    = pending_q[iss_rs1] | pending_q[iss_rs2] | pending_q[iss_rd];
  assign iss_ready = !hazard;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_any)
      rr_ptr_d = (g_idx == PW'(N_REQ - 1)) ? '0 : g_idx + PW'(1);

    reg_w_d  = grant_any && (g_rd != '0);
    rd_d     = grant_any ? g_rd   : rd_q;
    w_data_d = grant_any ? g_data : w_data_q;

    // Clear before set: a same-edge issue to the register being written wins.
    pending_d = pending_q;
    if (reg_w_q)
      pending_d[rd_q] = 1'b0;
    if (iss_valid && iss_ready && (iss_rd != '0))
      pending_d[iss_rd] = 1'b1;
    pending_d[0] = 1'b0;

    wb_err_d = wb_err_q | (reg_w_q && !pending_q[rd_q]);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q  <= '0;
      reg_w_q   <= 1'b0;
      rd_q      <= '0;
      w_data_q  <= '0;
      pending_q <= '0;
      wb_err_q  <= 1'b0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      reg_w_q   <= reg_w_d;
      rd_q      <= rd_d;
      w_data_q  <= w_data_d;
      pending_q <= pending_d;
      wb_err_q  <= wb_err_d;
    end
  end

  assign reg_w  = reg_w_q;
  assign rd     = rd_q;
  assign w_data = w_data_q;
  assign wb_err = wb_err_q;

endmodule

// File: tb/tb_x_wb_sched.sv
// Self-checking bench for x_wb_sched: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_x_wb_sched;

  localparam int N  = 3;
  localparam int XL = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [5*N-1:0]    req_rd = '0;
  logic [XL*N-1:0]   req_data = '0;
  logic [N-1:0]      req_ready;
  logic              iss_valid = 1'b0;
  logic [4:0]        iss_rd = '0, iss_rs1 = '0, iss_rs2 = '0;
  logic              iss_ready;
  logic              reg_w;
  logic [4:0]        rd;
  logic [XL-1:0]     w_data;
  logic              wb_err;

  x_wb_sched #(.N_REQ(N), .XLEN(XL)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
    .req_ready(req_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_ready(iss_ready),
    .reg_w(reg_w), .rd(rd), .w_data(w_data), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int          m_ptr;
  bit          m_pend [32];
  bit          m_reg_w;
  logic [4:0]  m_rd;
  logic [31:0] m_wdata;
  bit          m_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_reg_w = 1'b0;
    m_rd    = '0;
    m_wdata = '0;
    m_err   = 1'b0;
  endtask

  function automatic int exp_grant();
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic zero_inputs();
    req_valid = '0; req_rd = '0; req_data = '0;
    iss_valid = 1'b0; iss_rd = '0; iss_rs1 = '0; iss_rs2 = '0;
  endtask

  // One clock: compare every output at the negedge, then advance the model.
  task automatic cycle();
    int g;
    bit hz;
    bit          n_reg_w, n_err;
    logic [4:0]  n_rd;
    logic [31:0] n_wdata;
    int          n_ptr;
    bit          n_pend [32];
    @(negedge clk);
    g  = exp_grant();
    hz = m_pend[iss_rs1] | m_pend[iss_rs2] | m_pend[iss_rd];
    check("req_ready", 64'(req_ready), (g >= 0) ? 64'(1 << g) : 64'd0);
    check("iss_ready", 64'(iss_ready), 64'(!hz));
    check("reg_w",     64'(reg_w),     64'(m_reg_w));
    check("rd",        64'(rd),        64'(m_rd));
    check("w_data",    64'(w_data),    64'(m_wdata));
    check("wb_err",    64'(wb_err),    64'(m_err));

    n_pend = m_pend;
    n_err  = m_err;
    if (m_reg_w) begin
      if (!m_pend[m_rd]) n_err = 1'b1;
      n_pend[m_rd] = 1'b0;
    end
    if (iss_valid && !hz && iss_rd != 0) n_pend[iss_rd] = 1'b1;
    n_reg_w = 1'b0; n_rd = m_rd; n_wdata = m_wdata; n_ptr = m_ptr;
    if (g >= 0) begin
      n_rd    = req_rd[5*g +: 5];
      n_wdata = req_data[XL*g +: XL];
      n_reg_w = (n_rd != 0);
      n_ptr   = (g + 1) % N;
    end
    @(posedge clk);
    #1;
    m_pend = n_pend; m_err = n_err; m_reg_w = n_reg_w;
    m_rd = n_rd; m_wdata = n_wdata; m_ptr = n_ptr;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    zero_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    apply_reset();

    // Reset state
    #1;
    check("rst_reg_w",  64'(reg_w),  64'd0);
    check("rst_rd",     64'(rd),     64'd0);
    check("rst_w_data", 64'(w_data), 64'd0);
    check("rst_wb_err", 64'(wb_err), 64'd0);
    check("rst_iss_ready", 64'(iss_ready), 64'd1);

    // Single write
    iss_valid = 1'b1; iss_rd = 5'd5;
    cycle();
    iss_valid = 1'b0; iss_rd = '0;
    req_valid = 3'b001; req_rd[4:0] = 5'd5; req_data[31:0] = 32'hDEADBEEF;
    #1 check("single_ready", 64'(req_ready), 64'b001);
    cycle();
    req_valid = '0;
    #1;
    check("single_reg_w",  64'(reg_w),  64'd1);
    check("single_rd",     64'(rd),     64'd5);
    check("single_w_data", 64'(w_data), 64'hDEADBEEF);
    cycle();
    iss_rs1 = 5'd5;
    #1 check("single_pend5_clear", 64'(iss_ready), 64'd1);
    check("single_no_err", 64'(wb_err), 64'd0);

    // Contention from reset
    apply_reset();
    req_valid = 3'b111;
    for (int i = 0; i < N; i++) begin
      req_rd[5*i +: 5]    = 5'(10 + i);
      req_data[XL*i +: XL] = 32'h100 + 32'(i);
    end
    for (int k = 0; k < 6; k++) begin
      #1 check("contend_grant", 64'(req_ready), 64'(1 << (k % 3)));
      cycle();
      check("contend_reg_w", 64'(reg_w), 64'd1);
    end
    req_valid = '0;

    // RAW stall
    apply_reset();
    iss_valid = 1'b1; iss_rd = 5'd7;
    cycle();
    iss_rd = 5'd8; iss_rs1 = 5'd7;
    #1 check("raw_stall", 64'(iss_ready), 64'd0);
    req_valid = 3'b010; req_rd[9:5] = 5'd7; req_data[63:32] = 32'h0000_0077;
    cycle();
    req_valid = '0;
    #1;
    check("raw_wb_reg_w", 64'(reg_w), 64'd1);
    check("raw_still_stall", 64'(iss_ready), 64'd0);
    cycle();
    #1 check("raw_release", 64'(iss_ready), 64'd1);
    cycle();
    zero_inputs();

    // x0 write and error
    req_valid = 3'b001; req_rd[4:0] = 5'd0; req_data[31:0] = 32'h1234;
    #1 check("x0_ready", 64'(req_ready), 64'b001);
    cycle();
    req_valid = '0;
    #1 check("x0_no_write", 64'(reg_w), 64'd0);
    req_valid = 3'b001; req_rd[4:0] = 5'd9;
    cycle();
    req_valid = '0;
    #1 check("err_wr_reg_w", 64'(reg_w), 64'd1);
    cycle();
    #1 check("err_set", 64'(wb_err), 64'd1);
    repeat (3) cycle();
    check("err_sticky", 64'(wb_err), 64'd1);

    // Simultaneous set/clear
    apply_reset();
    req_valid = 3'b100; req_rd[14:10] = 5'd3;
    cycle();
    req_valid = '0;
    iss_valid = 1'b1; iss_rd = 5'd3;
    #1 check("setclr_issue_ok", 64'(iss_ready), 64'd1);
    cycle();
    iss_valid = 1'b0; iss_rd = '0; iss_rs1 = 5'd3;
    #1 check("setclr_pend3_set", 64'(iss_ready), 64'd0);
    iss_rs1 = '0;

    // Async reset with a write in flight and every register pending
    iss_valid = 1'b1;
    for (int r = 1; r < 32; r++) begin
      iss_rd = 5'(r);
      cycle();
    end
    iss_valid = 1'b0; iss_rd = '0;
    req_valid = 3'b001; req_rd[4:0] = 5'd4;
    cycle();
    req_valid = '0; iss_rs1 = 5'd4; iss_rs2 = 5'd17;
    #1 check("areset_pre_reg_w", 64'(reg_w), 64'd1);
    check("areset_pre_stall", 64'(iss_ready), 64'd0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("areset_reg_w",  64'(reg_w),  64'd0);
    check("areset_rd",     64'(rd),     64'd0);
    check("areset_w_data", 64'(w_data), 64'd0);
    check("areset_wb_err", 64'(wb_err), 64'd0);
    check("areset_pend_clr", 64'(iss_ready), 64'd1);
    zero_inputs();
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      if (n % 150 == 149) apply_reset();
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        req_rd[5*i +: 5]     = 5'($urandom_range(0, 31));
        req_data[XL*i +: XL] = $urandom;
      end
      iss_valid = 1'($urandom);
      iss_rd    = 5'($urandom_range(0, 31));
      iss_rs1   = 5'($urandom_range(0, 15));
      iss_rs2   = 5'($urandom_range(0, 15));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
